// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment encodings and capture FSM types
//
// Shared between the display driver and seg_capture so both ends agree on
// one anode/cathode table.
//   DIG0_N..DIG3_N : active-low one-hot anode patterns, digit 0 = MSB nibble
//   SEG_0..SEG_9   : active-low cathode patterns, bit order {g,f,e,d,c,b,a}
//   frame_state_t  : capture frame FSM states
//   anode_decode() : one-hot-low anode pattern to {ok, index}
package seg_pkg;

  localparam logic [3:0] DIG0_N = 4'b0111;
  localparam logic [3:0] DIG1_N = 4'b1011;
  localparam logic [3:0] DIG2_N = 4'b1101;
  localparam logic [3:0] DIG3_N = 4'b1110;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [6:0] SEG_TABLE [10] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4,
    SEG_5, SEG_6, SEG_7, SEG_8, SEG_9
  };

  // Nibble reported for any cathode pattern outside the table
  localparam logic [3:0] NIBBLE_ILLEGAL = 4'hF;

  typedef enum logic {
    ST_SEEK    = 1'b0,
    ST_COLLECT = 1'b1
  } frame_state_t;

  typedef struct packed {
    logic       ok;
    logic [1:0] idx;
  } anode_t;

  // Blank (1111), all-on (0000) and multi-low patterns report ok = 0
  function automatic anode_t anode_decode(input logic [3:0] an);
    anode_t r;
    r.ok  = 1'b1;
    r.idx = 2'd0;
    case (an)
      DIG0_N:  r.idx = 2'd0;
      DIG1_N:  r.idx = 2'd1;
      DIG2_N:  r.idx = 2'd2;
      DIG3_N:  r.idx = 2'd3;
      default: r.ok  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - seven-segment cathode pattern to BCD nibble decoder
//
// Purely combinational.
//   pattern : active-low cathodes {g,f,e,d,c,b,a}
//   legal   : 1 when pattern is one of the ten digit glyphs
//   nibble  : decoded digit 0..9, or 4'hF when not legal
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       legal,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b0;
    nibble = NIBBLE_ILLEGAL;
    for (int i = 0; i < 10; i++) begin
      if (pattern == SEG_TABLE[i]) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - multiplexed seven-segment display capture and frame rebuild
//
// Watches the anode/cathode lines of a scanned four-digit display, waits for
// each digit to settle, decodes it and assembles digits 0..3 in scan order
// into a 16-bit BCD frame.
//   CLK       : system clock
//   reset_n   : asynchronous active-low reset
//   digits    : active-low one-hot anode lines (0111 = digit 0)
//   segments  : active-low cathode lines {g,f,e,d,c,b,a}
//   value     : last published frame, digit 0 in [15:12]
//   valid     : one-cycle pulse when value/frame_err update
//   frame_err : published frame contained an illegal glyph
//   stale     : no digit accepted for TIMEOUT_CYCLES
// Build option SEG_CAPTURE_CONFIRM_EN: publish a frame only when it equals
// the immediately preceding completed frame (value and error flag).
module seg_capture
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic [3:0]  digits,
  input  logic [6:0]  segments,
  output logic [15:0] value,
  output logic        valid,
  output logic        frame_err,
  output logic        stale
);

  // The accept event fires on the cycle the counter would step from
  // SETTLE_CYCLES-1 to SETTLE_CYCLES; the counter then parks at SETTLE_CYCLES.
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  SETTLE_MAX  = 8'(SETTLE_CYCLES);
  localparam logic [31:0] WD_MAX      = 32'(TIMEOUT_CYCLES);

  // ---------------------------------------------------------------------
  // Input synchronizers and previous-cycle copy for change detection
  // ---------------------------------------------------------------------
  logic [3:0] dig_meta, dig_sync, dig_prev;
  logic [6:0] seg_meta, seg_sync, seg_prev;
  logic [7:0] settle_cnt;
  logic       pair_changed;
  logic       accept;
  anode_t     anode;

  assign anode        = anode_decode(dig_sync);
  assign pair_changed = (dig_sync != dig_prev) || (seg_sync != seg_prev);
  assign accept       = anode.ok && !pair_changed && (settle_cnt == SETTLE_LAST);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      dig_meta   <= '0;
      dig_sync   <= '0;
      dig_prev   <= '0;
      seg_meta   <= '0;
      seg_sync   <= '0;
      seg_prev   <= '0;
      settle_cnt <= '0;
    end else begin
      dig_meta <= digits;
      dig_sync <= dig_meta;
      dig_prev <= dig_sync;
      seg_meta <= segments;
      seg_sync <= seg_meta;
      seg_prev <= seg_sync;
      // Non-digit anode states pin the counter at zero so blanking between
      // digits can never produce an accept.
      if (pair_changed || !anode.ok) begin
        settle_cnt <= '0;
      end else if (settle_cnt != SETTLE_MAX) begin
        settle_cnt <= settle_cnt + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Watchdog: stale tracks wd_cnt == WD_MAX as a registered flag
  // ---------------------------------------------------------------------
  logic [31:0] wd_cnt;
  logic [31:0] wd_next;

  always_comb begin
    wd_next = wd_cnt;
    if (accept) begin
      wd_next = '0;
    end else if (wd_cnt != WD_MAX) begin
      wd_next = wd_cnt + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
      stale  <= 1'b0;
    end else begin
      wd_cnt <= wd_next;
      stale  <= (wd_next == WD_MAX);
    end
  end

  // ---------------------------------------------------------------------
  // Glyph decode of the synchronized cathodes
  // ---------------------------------------------------------------------
  logic       dec_legal;
  logic [3:0] dec_nibble;

  seg_decode u_decode (
    .pattern (seg_sync),
    .legal   (dec_legal),
    .nibble  (dec_nibble)
  );

  // ---------------------------------------------------------------------
  // Frame assembly
  // ---------------------------------------------------------------------
  frame_state_t state;
  logic [1:0]   exp_idx;
  logic [15:0]  frame_buf;
  logic         err_acc;
  logic [15:0]  done_value;
  logic         done_err;
  logic         publish_ok;

  // Frame as it stands once the digit-3 glyph currently being accepted lands
  assign done_value = {frame_buf[15:4], dec_nibble};
  assign done_err   = err_acc | ~dec_legal;

`ifdef SEG_CAPTURE_CONFIRM_EN
  logic        shadow_ok;
  logic [15:0] shadow_value;
  logic        shadow_err;

  assign publish_ok = shadow_ok && (shadow_value == done_value) && (shadow_err == done_err);
`else
  assign publish_ok = 1'b1;
`endif

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_SEEK;
      exp_idx   <= 2'd0;
      frame_buf <= '0;
      err_acc   <= 1'b0;
      value     <= '0;
      frame_err <= 1'b0;
      valid     <= 1'b0;
`ifdef SEG_CAPTURE_CONFIRM_EN
      shadow_ok    <= 1'b0;
      shadow_value <= '0;
      shadow_err   <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      if (accept) begin
        case (state)
          ST_SEEK: begin
            if (anode.idx == 2'd0) begin
              frame_buf[15:12] <= dec_nibble;
              err_acc          <= ~dec_legal;
              exp_idx          <= 2'd1;
              state            <= ST_COLLECT;
            end
          end
          ST_COLLECT: begin
            if (anode.idx == exp_idx) begin
              case (exp_idx)
                2'd1:    frame_buf[11:8] <= dec_nibble;
                2'd2:    frame_buf[7:4]  <= dec_nibble;
                default: frame_buf[3:0]  <= dec_nibble;
              endcase
              err_acc <= done_err;
              if (exp_idx == 2'd3) begin
                state <= ST_SEEK;
                if (publish_ok) begin
                  value     <= done_value;
                  frame_err <= done_err;
                  valid     <= 1'b1;
                end
`ifdef SEG_CAPTURE_CONFIRM_EN
                shadow_ok    <= 1'b1;
                shadow_value <= done_value;
                shadow_err   <= done_err;
`endif
              end else begin
                exp_idx <= exp_idx + 2'd1;
              end
            end else if (anode.idx == 2'd0) begin
              // Digit 0 seen early: the scan restarted, begin a fresh frame
              frame_buf[15:12] <= dec_nibble;
              err_acc          <= ~dec_legal;
              exp_idx          <= 2'd1;
            end else begin
              // Skipped or reordered digit: the frame cannot be trusted
              state <= ST_SEEK;
`ifdef SEG_CAPTURE_CONFIRM_EN
              shadow_ok <= 1'b0;
`endif
            end
          end
          default: state <= ST_SEEK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// tb/tb_seg_capture.sv - self-checking bench for seg_capture
module tb_seg_capture;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 500;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  digits = 4'hF;
  logic [6:0]  segments = 7'h7F;
  logic [15:0] value;
  logic        valid;
  logic        frame_err;
  logic        stale;

  seg_capture #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .digits    (digits),
    .segments  (segments),
    .value     (value),
    .valid     (valid),
    .frame_err (frame_err),
    .stale     (stale)
  );

  always #5 CLK = ~CLK;

  logic [6:0] seg_lut [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [3:0] an_lut [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [6:0] BLANK = 7'b1111111;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [15:0] obs_val [$];
  logic        obs_err [$];
  logic [15:0] exp_val [$];
  logic        exp_err [$];
  int          dbl_valid = 0;
  logic        prev_valid = 1'b0;

  // Reference frame model state
  int          m_have;
  logic [15:0] m_buf;
  logic        m_err;
  logic        m_sh_ok;
  logic [15:0] m_sh_val;
  logic        m_sh_err;
  logic [15:0] m_last;

  always @(negedge CLK) begin
    if (valid) begin
      obs_val.push_back(value);
      obs_err.push_back(frame_err);
    end
    if (valid && prev_valid) dbl_valid++;
    prev_valid = valid;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] pat(input int n);
    return (n >= 0 && n < 10) ? seg_lut[n] : BLANK;
  endfunction

  task automatic model_reset();
    m_have  = 0;
    m_buf   = '0;
    m_err   = 1'b0;
    m_sh_ok = 1'b0;
    m_sh_val = '0;
    m_sh_err = 1'b0;
    m_last  = '0;
  endtask

  task automatic model_publish(input logic [15:0] v, input logic e);
    exp_val.push_back(v);
    exp_err.push_back(e);
    m_last = v;
  endtask

  task automatic model_complete(input logic [15:0] v, input logic e);
`ifdef SEG_CAPTURE_CONFIRM_EN
    if (m_sh_ok && m_sh_val == v && m_sh_err == e) model_publish(v, e);
    m_sh_ok  = 1'b1;
    m_sh_val = v;
    m_sh_err = e;
`else
    model_publish(v, e);
`endif
  endtask

  // One settled digit: decode by table lookup and apply the scan-order rules
  task automatic model_accept(input int idx, input logic [6:0] sg);
    int   nib;
    logic ok;
    nib = 15;
    ok  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (sg == seg_lut[k]) begin
        nib = k;
        ok  = 1'b1;
      end
    end
    if (idx == 0) begin
      m_have = 1;
      m_buf  = {nib[3:0], 12'h000};
      m_err  = !ok;
    end else if (m_have > 0 && idx == m_have) begin
      m_buf[15 - 4 * idx -: 4] = nib[3:0];
      m_err  = m_err | !ok;
      m_have = m_have + 1;
      if (m_have == 4) begin
        m_have = 0;
        model_complete(m_buf, m_err);
      end
    end else if (m_have > 0) begin
      m_have  = 0;
      m_sh_ok = 1'b0;
    end
  endtask

  // Hold a pattern at the pins for cyc clocks; long-enough one-hot holds are accepted
  task automatic dwell(input logic [3:0] an, input logic [6:0] sg, input int cyc);
    digits   = an;
    segments = sg;
    repeat (cyc) @(negedge CLK);
    if (cyc >= SETTLE + 2) begin
      for (int k = 0; k < 4; k++) begin
        if (an == an_lut[k]) model_accept(k, sg);
      end
    end
  endtask

  task automatic scan4(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                       input logic [6:0] p3, input int dw, input bit glitchy);
    logic [6:0] p [4];
    p = '{p0, p1, p2, p3};
    for (int i = 0; i < 4; i++) begin
      if (glitchy) dwell(4'($urandom), 7'($urandom), $urandom_range(1, SETTLE - 1));
      dwell(an_lut[i], p[i], dw);
    end
  endtask

  task automatic checkpoint(input string tag);
    int n;
    @(negedge CLK);
    #1;
    check({tag, "_count"}, obs_val.size(), exp_val.size());
    n = (obs_val.size() < exp_val.size()) ? obs_val.size() : exp_val.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_value"}, obs_val[i], exp_val[i]);
      check({tag, "_err"}, obs_err[i], exp_err[i]);
    end
    check({tag, "_stale"}, stale, 1'b0);
    obs_val.delete();
    obs_err.delete();
    exp_val.delete();
    exp_err.delete();
  endtask

  initial begin
    int lat;
    bit seen;
    model_reset();
    repeat (3) @(negedge CLK);
    #1;
    check("reset_value", value, 16'h0000);
    check("reset_valid", valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_stale", stale, 1'b0);
    @(negedge CLK);
    reset_n = 1'b1;

    // Display 1234: first scan, then second scan with digit-3 latency measured
    scan4(pat(1), pat(2), pat(3), pat(4), 40, 1'b0);
    checkpoint("scan1_1234");
    dwell(an_lut[0], pat(1), 40);
    dwell(an_lut[1], pat(2), 40);
    dwell(an_lut[2], pat(3), 40);
    digits   = an_lut[3];
    segments = pat(4);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge CLK);
      lat++;
      if (valid) seen = 1'b1;
    end
    check("valid_latency", lat, SETTLE + 3);
    check("first_value", value, 16'h1234);
    check("first_frame_err", frame_err, 1'b0);
    repeat (40 - lat) @(negedge CLK);
    model_accept(3, pat(4));
    checkpoint("scan2_1234");

    // Blank digit 2
    scan4(pat(1), pat(2), BLANK, pat(4), 40, 1'b0);
    scan4(pat(1), pat(2), BLANK, pat(4), 40, 1'b0);
    checkpoint("blank_digit");

    // Random values, occasional illegal glyphs, glitches at every digit change
    for (int s = 0; s < 5; s++) begin
      logic [6:0] rp [4];
      int dw;
      for (int i = 0; i < 4; i++) begin
        rp[i] = ($urandom_range(0, 7) == 0) ? 7'($urandom) : seg_lut[$urandom_range(0, 9)];
      end
      dw = $urandom_range(SETTLE + 4, 40);
      scan4(rp[0], rp[1], rp[2], rp[3], dw, 1'b1);
      scan4(rp[0], rp[1], rp[2], rp[3], dw, 1'b1);
      checkpoint("random_glitch");
    end

    // Out-of-order scan 0,1,3,2, then correct scans
    dwell(an_lut[0], pat(5), 30);
    dwell(an_lut[1], pat(6), 30);
    dwell(an_lut[3], pat(8), 30);
    dwell(an_lut[2], pat(7), 30);
    checkpoint("out_of_order");
    scan4(pat(5), pat(6), pat(7), pat(8), 30, 1'b0);
    scan4(pat(5), pat(6), pat(7), pat(8), 30, 1'b0);
    checkpoint("after_reorder");

    // Stale watchdog
    dwell(4'b1111, BLANK, TIMEOUT + 20);
    check("stale_set", stale, 1'b1);
    digits   = an_lut[0];
    segments = pat(9);
    repeat (SETTLE + 2) @(negedge CLK);
    check("stale_hold", stale, 1'b1);
    @(negedge CLK);
    check("stale_clear", stale, 1'b0);
    repeat (40 - SETTLE - 3) @(negedge CLK);
    model_accept(0, pat(9));
    dwell(an_lut[1], pat(8), 40);
    dwell(an_lut[2], pat(7), 40);
    dwell(an_lut[3], pat(6), 40);
    checkpoint("post_stale");

    // Reset while waiting for digit 2
    dwell(an_lut[0], pat(4), 40);
    dwell(an_lut[1], pat(3), 40);
    check("pre_reset_value", value, m_last);
    digits   = an_lut[2];
    segments = pat(2);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_value", value, 16'h0000);
    check("midreset_valid", valid, 1'b0);
    check("midreset_frame_err", frame_err, 1'b0);
    check("midreset_stale", stale, 1'b0);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    reset_n = 1'b1;
    dwell(an_lut[2], pat(2), 40);
    dwell(an_lut[3], pat(1), 40);
    checkpoint("reset_partial");
    check("reset_partial_value", value, 16'h0000);
    scan4(pat(4), pat(3), pat(2), pat(1), 40, 1'b0);
    scan4(pat(4), pat(3), pat(2), pat(1), 40, 1'b0);
    checkpoint("reset_full");

    check("no_back_to_back_valid", dbl_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
# seg_capture

Capture-side counterpart of the multiplexed seven-segment display driver. It watches the active-low anode (`digits`) and cathode (`segments`) lines and reconstructs the displayed 16-bit BCD value: it waits for each digit to settle, decodes the segment pattern, and assembles four digits in scan order into a frame. It sits beside the display driver for on-board self-test and for closed-loop checking of the frequency readout in simulation.

## Interface
- `SETTLE_CYCLES`, default 16: consecutive identical samples required before a digit is accepted (range 2..255).
- `TIMEOUT_CYCLES`, default 2_000_000: cycles without an accepted digit before `stale` asserts.
- `CLK` input, 1 bit: system clock, 100 MHz.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `digits` input, 4 bits: anode lines, active-low one-hot. 0111 = digit 0 (MSB nibble), 1011 = digit 1, 1101 = digit 2, 1110 = digit 3.
- `segments` input, 7 bits: cathode lines, active-low, {g,f,e,d,c,b,a}. 1000000 = "0".
- `value` output, 16 bits: last published frame, digit 0 in [15:12].
- `valid` output, 1 bit: one-cycle pulse when `value` updates.
- `frame_err` output, 1 bit: the published frame contained at least one illegal segment pattern. Updates together with `value`.
- `stale` output, 1 bit: no digit accepted for `TIMEOUT_CYCLES`.

## Operation
- **Synchronizer.** `digits` and `segments` each pass through a 2-flop synchronizer. All logic below uses the synchronized pair.
- **Settle filter.**
  - Compare the synchronized pair with its previous-cycle value. On any change, clear the settle counter.
  - When the counter reaches `SETTLE_CYCLES`, fire one "accept" event. Then hold the counter saturated with no further events until the pair changes.
  - Anode patterns that are not one-hot-low (1111, 0000, multiple lows) never fire accept. They hold the counter at 0.
- **Decode.**
  - Patterns for 0–9 map to their nibble with legal = 1.
  - Any other pattern maps to 4'hF with legal = 0.
- **Frame FSM**, states SEEK and COLLECT, with an expected index `exp` (2 bits).
  - SEEK: on accept of digit 0, store the nibble, set `err_acc` = !legal, set `exp` = 1, go to COLLECT. Accepts of digits 1–3 are ignored.
  - COLLECT, accept with index == `exp`: store the nibble and OR !legal into `err_acc`.
    - If `exp` == 3: publish and return to SEEK.
    - Otherwise: increment `exp`.
  - COLLECT, accept of digit 0 out of order: restart the frame as in SEEK.
  - COLLECT, accept of any other index out of order: drop the frame and return to SEEK.
- **Publish.** Load `value` and `frame_err` and pulse `valid`, all in the same cycle.
- **Stale.**
  - A watchdog counter clears on every accept and saturates at `TIMEOUT_CYCLES`.
  - `stale` = 1 while saturated.
  - `stale` clears on the cycle after the next accept.
- **Reset.** Asynchronous `reset_n` low at any time (including mid-frame) resets everything:
  - FSM to SEEK.
  - `value` = 0, `valid` = 0, `frame_err` = 0, `stale` = 0.
  - Settle counter, watchdog and synchronizers to 0.

## Timing
- Input to accept: the pair must be stable at the pins for ≥ `SETTLE_CYCLES` + 2 cycles. 2 synchronizer cycles + `SETTLE_CYCLES`.
- Accept of digit 3 to `valid`: 1 cycle. `value` and `frame_err` are valid in the same cycle as `valid`.
- `valid` is never asserted on two consecutive cycles. The minimum frame period is 4 × (`SETTLE_CYCLES` + 1).
- Driven by the 190 Hz display scan: about 1.3 ms per digit, so one frame every about 5.2 ms.
- A digit change mid-settle restarts that digit's settle window and does not affect the frame state.

## Configuration
- `SEG_CAPTURE_CONFIRM_EN`
  - **Defined:** a completed frame is published only if its value and error flag equal those of the immediately preceding completed frame. The first frame after reset, or after a change, is held in a shadow register and not published. `valid` then follows the second matching frame.
  - **Undefined:** every completed frame is published immediately and there is no shadow register.
  - A dropped frame clears the shadow match in both cases.

## Structure
- Package `seg_pkg` holds:
  - Anode pattern constants (`DIG0_N`..`DIG3_N`).
  - The 10 segment pattern constants, shared with the display driver so both ends use one table.
  - The FSM state typedef.
- Sub-module `seg_decode`: combinational 7-bit pattern to {legal, nibble[3:0]}.

## Test plan
- Scan digits showing 1,2,3,4 (segments 1111001, 0100100, 0110000, 0011001), 40 cycles each, 2 scans → first `valid` with `value` = 16'h1234, `frame_err` = 0. Under `SEG_CAPTURE_CONFIRM_EN`, the pulse comes only after the second scan.
- Digit 2 shows 1111111 (blank) → `value` = 16'h12F4, `frame_err` = 1.
- Glitches of 1..`SETTLE_CYCLES`−1 cycles inserted at each digit change → no extra accepts, same frame, `valid` pulses exactly once per scan.
- Scan order 0,1,3,2 → no `valid`. The following correct scan publishes normally.
- Hold `digits` = 1111 for `TIMEOUT_CYCLES` → `stale` = 1. Resume scanning → `stale` = 0 one cycle after the first accept.
- Assert `reset_n` = 0 while the FSM waits for digit 2 → all outputs 0 immediately. After release, a full scan is required before `valid`.
